bus_activity_monitor: RTL and testbench

Parametrised switching-activity monitor for the encoded bus, replacing the fixed 37-bit transition counter in the datapath. It taps the bus word after the bus mux and accumulates a per-word histogram of either self-transitions (bit toggles) or coupling events (adjacent bits switching in opposite directions). On request, a sequential scan FSM computes the peak bin and the weighted sum. Individual bins can be read back over a simple request/valid port, so the power-analysis harness sees the full distribution.

---
 rtl/peecc_mon_pkg.sv | 29 ++
 rtl/bus_metric_calc.sv | 33 +++
 rtl/bus_activity_monitor.sv | 235 +++++++++++++++++++++++
 tb/tb_bus_activity_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peecc_mon_pkg.sv
// Shared definitions for the bus activity monitor: FSM states, metric modes
// and the saturating adder used by both the bins and the weighted sum.
package peecc_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SCAN   = 2'd2,
        ST_REPORT = 2'd3
    } mon_state_e;

    typedef enum logic {
        MODE_TOGGLE   = 1'b0,
        MODE_COUPLING = 1'b1
    } mon_mode_e;

    // Callers size-cast the result down to their own width; limit must fit that width.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] limit);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, limit}) begin
            return limit;
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/bus_metric_calc.sv
// Combinational switching metric between two consecutive bus words:
// bit-toggle count or opposite-direction adjacent-pair (coupling) count.
import peecc_mon_pkg::*;

module bus_metric_calc #(
    parameter int N = 37,
    localparam int BW = $clog2(N + 1)
) (
    input  logic [N-1:0]  cur,
    input  logic [N-1:0]  prev,
    input  logic          mode,
    output logic [BW-1:0] m
);

    logic [N-1:0]  diff;
    logic [BW-1:0] toggles;
    logic [BW-1:0] couples;

    // A pair couples when both bits toggle and end up at different values.
    always_comb begin
        diff    = cur ^ prev;
        toggles = '0;
        couples = '0;
        for (int i = 0; i < N; i++) begin
            toggles = toggles + BW'(diff[i]);
        end
        for (int i = 0; i < N - 1; i++) begin
            couples = couples + BW'(diff[i] & diff[i+1] & (cur[i] ^ cur[i+1]));
        end
        m = (mode == MODE_COUPLING) ? couples : toggles;
    end

endmodule

// File: rtl/bus_activity_monitor.sv
// Switching-activity histogram for the encoded bus with a sequential summary
// scan (peak bin, weighted sum) and a one-cycle bin readout port.
import peecc_mon_pkg::*;

module bus_activity_monitor #(
    parameter int N  = 37,
    parameter int CW = 11,
    parameter int SW = 22,
    localparam int BW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic [N-1:0]  data_in,
    input  logic          mode,
    input  logic          done,
    output logic          busy,
    output logic          sum_valid,
    output logic [BW-1:0] max_bin,
    output logic [CW-1:0] max_count,
    output logic [SW-1:0] sum_value,
    input  logic          rd_en,
    input  logic [BW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [CW-1:0] rd_data
);

    localparam logic [63:0]   BIN_MAX  = (64'd1 << CW) - 64'd1;
    localparam logic [63:0]   SUM_MAX  = (64'd1 << SW) - 64'd1;
    localparam logic [BW-1:0] LAST_IDX = BW'(N);

    mon_state_e state_q, state_d;
    logic       is_idle, scan_load, scan_step, scan_last;

    logic [N-1:0]  prev_q, prev_d;
    logic          primed_q, primed_d;
    logic          mode_q, mode_d;
    logic [BW-1:0] m_calc;
    logic [BW-1:0] m_q, m_d;
    logic          inc_valid_q, inc_valid_d;
    logic [CW-1:0] bins_q [N+1];
    logic [CW-1:0] bins_d [N+1];

    logic [BW-1:0] idx_q, idx_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] run_max_q, run_max_d;
    logic [BW-1:0] run_bin_q, run_bin_d;
    logic [BW-1:0] max_bin_q, max_bin_d;
    logic [CW-1:0] max_count_q, max_count_d;
    logic [SW-1:0] sum_value_q, sum_value_d;
    logic          rd_valid_q, rd_valid_d;
    logic [CW-1:0] rd_data_q, rd_data_d;

    logic [CW-1:0] scan_bin;
    logic [CW-1:0] rd_bin;
    logic [SW-1:0] acc_next;

    bus_metric_calc #(.N(N)) u_metric (
        .cur  (data_in),
        .prev (prev_q),
        .mode (mode_q),
        .m    (m_calc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (done) state_d = ST_DRAIN;
                ST_DRAIN:  state_d = ST_SCAN;
                ST_SCAN:   if (idx_q == LAST_IDX) state_d = ST_REPORT;
                ST_REPORT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        is_idle   = (state_q == ST_IDLE);
        scan_load = (state_q == ST_DRAIN);
        scan_step = (state_q == ST_SCAN);
        scan_last = (state_q == ST_SCAN) && (idx_q == LAST_IDX);
        busy      = (state_q != ST_IDLE);
        sum_valid = (state_q == ST_REPORT);
    end

    // Scan and readout select their bins independently so both can share the array.
    always_comb begin
        scan_bin = '0;
        rd_bin   = '0;
        for (int i = 0; i <= N; i++) begin
            if (idx_q == BW'(i)) scan_bin = bins_q[i];
            if (rd_idx == BW'(i)) rd_bin = bins_q[i];
        end
        acc_next = SW'(sat_add(64'(acc_q), 64'(scan_bin) * 64'(idx_q), SUM_MAX));
    end

    always_comb begin
        prev_d      = prev_q;
        primed_d    = primed_q;
        mode_d      = mode_q;
        m_d         = m_q;
        inc_valid_d = 1'b0;
        bins_d      = bins_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        run_max_d   = run_max_q;
        run_bin_d   = run_bin_q;
        max_bin_d   = max_bin_q;
        max_count_d = max_count_q;
        sum_value_d = sum_value_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;

        // The first accepted word after reset/clear only primes prev and the mode.
        if (is_idle && en) begin
            prev_d = data_in;
            if (!primed_q) begin
                primed_d = 1'b1;
                mode_d   = mode;
            end else begin
                m_d         = m_calc;
                inc_valid_d = 1'b1;
            end
        end

        for (int i = 0; i <= N; i++) begin
            if (inc_valid_q && (m_q == BW'(i))) begin
                bins_d[i] = CW'(sat_add(64'(bins_q[i]), 64'd1, BIN_MAX));
            end
        end

        if (scan_load) begin
            idx_d     = '0;
            acc_d     = '0;
            run_max_d = '0;
            run_bin_d = '0;
        end

        // Strict compare keeps the lowest index on ties.
        if (scan_step) begin
            acc_d = acc_next;
            if (scan_bin > run_max_q) begin
                run_max_d = scan_bin;
                run_bin_d = idx_q;
            end
            if (!scan_last) begin
                idx_d = idx_q + BW'(1);
            end
        end

        if (scan_last) begin
            max_bin_d   = run_bin_d;
            max_count_d = run_max_d;
            sum_value_d = acc_d;
        end

        if (is_idle && rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = (rd_idx > LAST_IDX) ? '0 : rd_bin;
        end

        if (clear) begin
            prev_d      = '0;
            primed_d    = 1'b0;
            mode_d      = 1'b0;
            m_d         = '0;
            inc_valid_d = 1'b0;
            for (int i = 0; i <= N; i++) bins_d[i] = '0;
            idx_d       = '0;
            acc_d       = '0;
            run_max_d   = '0;
            run_bin_d   = '0;
            max_bin_d   = '0;
            max_count_d = '0;
            sum_value_d = '0;
            rd_valid_d  = 1'b0;
            rd_data_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            primed_q    <= 1'b0;
            mode_q      <= 1'b0;
            m_q         <= '0;
            inc_valid_q <= 1'b0;
            for (int i = 0; i <= N; i++) bins_q[i] <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            run_max_q   <= '0;
            run_bin_q   <= '0;
            max_bin_q   <= '0;
            max_count_q <= '0;
            sum_value_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            mode_q      <= mode_d;
            m_q         <= m_d;
            inc_valid_q <= inc_valid_d;
            bins_q      <= bins_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            run_max_q   <= run_max_d;
            run_bin_q   <= run_bin_d;
            max_bin_q   <= max_bin_d;
            max_count_q <= max_count_d;
            sum_value_q <= sum_value_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign max_bin   = max_bin_q;
    assign max_count = max_count_q;
    assign sum_value = sum_value_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Directed bench for bus_activity_monitor at N=8 with narrow bins and sum
// so that saturation, tie-breaking and summary timing are all reachable.
module tb_bus_activity_monitor;

    localparam int N  = 8;
    localparam int CW = 3;
    localparam int SW = 5;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          en = 1'b0;
    logic [N-1:0]  data_in = '0;
    logic          mode = 1'b0;
    logic          done = 1'b0;
    logic          busy;
    logic          sum_valid;
    logic [BW-1:0] max_bin;
    logic [CW-1:0] max_count;
    logic [SW-1:0] sum_value;
    logic          rd_en = 1'b0;
    logic [BW-1:0] rd_idx = '0;
    logic          rd_valid;
    logic [CW-1:0] rd_data;

    int checksTotal  = 0;
    int checksPassed = 0;

    bus_activity_monitor #(.N(N), .CW(CW), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .en        (en),
        .data_in   (data_in),
        .mode      (mode),
        .done      (done),
        .busy      (busy),
        .sum_valid (sum_valid),
        .max_bin   (max_bin),
        .max_count (max_count),
        .sum_value (sum_value),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [N-1:0] d);
        en      = e;
        data_in = d;
        tick();
        en = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic readBin(input logic [BW-1:0] idx, input int expected, input string tag);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en = 1'b0;
        checkOutput({tag, "_valid"}, 32'(rd_valid), 1);
        checkOutput(tag, 32'(rd_data), expected);
    endtask

    // Pulses done (optionally with a sample) and expects sum_valid 11 cycles later.
    task automatic runSummary(input logic sampleEn, input logic [N-1:0] sampleData,
                              input int expBin, input int expCount, input int expSum,
                              input string tag);
        int  cycles;
        bit  seen;
        done    = 1'b1;
        en      = sampleEn;
        data_in = sampleData;
        cycles  = 0;
        seen    = 1'b0;
        while (cycles < 60 && !seen) begin
            tick();
            done = 1'b0;
            en   = 1'b0;
            cycles++;
            if (cycles == 1) checkOutput({tag, "_busy_high"}, 32'(busy), 1);
            if (sum_valid) seen = 1'b1;
        end
        checkOutput({tag, "_latency"}, cycles, 11);
        checkOutput({tag, "_max_bin"}, 32'(max_bin), expBin);
        checkOutput({tag, "_max_count"}, 32'(max_count), expCount);
        checkOutput({tag, "_sum"}, 32'(sum_value), expSum);
        tick();
        checkOutput({tag, "_busy_low"}, 32'(busy), 0);
        checkOutput({tag, "_pulse_one_cycle"}, 32'(sum_valid), 0);
    endtask

    initial begin
        int cycles;
        int svCount;

        tick();
        tick();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_sum_valid", 32'(sum_valid), 0);
        checkOutput("rst_max_count", 32'(max_count), 0);
        checkOutput("rst_sum", 32'(sum_value), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] toggle histogram and tie-break");
        mode = 1'b0;
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h0F);
        tick();
        readBin(4'd8, 1, "t1_bin8");
        readBin(4'd0, 1, "t1_bin0");
        readBin(4'd4, 1, "t1_bin4");
        readBin(4'd1, 0, "t1_bin1");
        runSummary(1'b0, 8'h00, 0, 1, 12, "t1");

        $display("[TB] coupling mode and latched mode");
        doClear();
        mode = 1'b1;
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h02);
        mode = 1'b0;
        applyStimulus(1'b1, 8'h01);
        tick();
        readBin(4'd1, 2, "t2_bin1");
        readBin(4'd0, 1, "t2_bin0");
        readBin(4'd3, 0, "t2_bin3");

        $display("[TB] saturation of bins and sum");
        doClear();
        mode = 1'b0;
        applyStimulus(1'b1, 8'h00);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i % 2 == 0) ? 8'hFF : 8'h00);
        tick();
        readBin(4'd0, 7, "t3_bin0_sat");
        readBin(4'd8, 5, "t3_bin8");
        runSummary(1'b0, 8'h00, 0, 7, 31, "t3");

        $display("[TB] samples during scan are dropped");
        doClear();
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        tick();
        tick();
        done    = 1'b1;
        cycles  = 0;
        svCount = 0;
        while (cycles < 60 && svCount == 0) begin
            tick();
            cycles++;
            done    = (cycles == 5);
            en      = 1'b1;
            data_in = (cycles % 2 == 0) ? 8'h0F : 8'h00;
            if (sum_valid) svCount++;
        end
        en   = 1'b0;
        done = 1'b0;
        checkOutput("t4_latency", cycles, 11);
        checkOutput("t4_max_bin", 32'(max_bin), 8);
        checkOutput("t4_sum", 32'(sum_value), 8);
        tick();
        tick();
        tick();
        checkOutput("t4_done_in_scan_ignored", 32'(busy), 0);
        applyStimulus(1'b1, 8'hFF);
        runSummary(1'b1, 8'h00, 8, 2, 16, "t4b");
        readBin(4'd0, 1, "t4_bin0");
        readBin(4'd4, 0, "t4_bin4");

        $display("[TB] clear during scan");
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        rd_en  = 1'b1;
        rd_idx = 4'd8;
        tick();
        rd_en = 1'b0;
        checkOutput("t5_rd_in_scan", 32'(rd_valid), 0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("t5_busy", 32'(busy), 0);
        checkOutput("t5_max_count", 32'(max_count), 0);
        checkOutput("t5_max_bin", 32'(max_bin), 0);
        checkOutput("t5_sum", 32'(sum_value), 0);
        svCount = 0;
        for (int i = 0; i < 15; i++) begin
            if (sum_valid) svCount++;
            tick();
        end
        checkOutput("t5_no_sum_valid", svCount, 0);
        readBin(4'd8, 0, "t5_bin8_cleared");
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        tick();
        readBin(4'd0, 0, "t5_prime_only");
        readBin(4'd8, 1, "t5_bin8");

        $display("[TB] out-of-range read and async reset");
        readBin(4'd9, 0, "t6_rd_oob");
        runSummary(1'b0, 8'h00, 8, 1, 8, "t6");
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 32'(busy), 0);
        checkOutput("t6_rst_max_bin", 32'(max_bin), 0);
        checkOutput("t6_rst_max_count", 32'(max_count), 0);
        checkOutput("t6_rst_sum", 32'(sum_value), 0);
        #1;
        rst_n = 1'b1;
        tick();
        readBin(4'd8, 0, "t6_bin8_after_rst");

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
